mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  - Shares one single-port byte-addressed memory (negedge-registered, size/sign-aware) between the
//    instruction-fetch (IF) requester and the load/store (LS) requester.
//  - Req/ack handshake per requester; round-robin on conflict; one access in flight at a time.
//  - Sits between the core pipeline and the unified memory array; owns MEM_WE qualification.
// PARAMETERS
//  - ADDR_W    16  byte address width
//  - DATA_W    32  data width (fixed 32; parameter for checking only)
//  - IF_FIRST  1   1: IF wins the first tie after reset; 0: LS wins it
// PORTS
//  - CLK           in   1       clock; all state on posedge
//  - RST           in   1       asynchronous, active-high reset
//  - IF_REQ        in   1       fetch request; held with IF_ADDR until IF_ACK
//  - IF_ADDR       in   ADDR_W  fetch byte address
//  - IF_ACK        out  1       one-cycle pulse, IF_RDATA valid
//  - IF_RDATA      out  32      fetched word (little-endian)
//  - LS_REQ        in   1       load/store request; all LS_* inputs held until LS_ACK
//  - LS_WE         in   1       1 = store, 0 = load
//  - LS_ADDR       in   ADDR_W  byte address
//  - LS_WDATA      in   32      store data (low bytes used for byte/half)
//  - LS_SIZE       in   2       00 byte, 01 half, 10 word, 11 invalid
//  - LS_SIGNED     in   1       sign-extend load
//  - LS_ACK        out  1       one-cycle pulse, access done
//  - LS_RDATA      out  32      load result
//  - LS_ERR        out  1       valid with LS_ACK; see CONFIGURATION
//  - MEM_WE        out  1       memory write enable
//  - MEM_ADDR      out  ADDR_W  memory address
//  - MEM_DATA_IN   out  32      memory write data
//  - MEM_SIZE      out  2       memory access size
//  - MEM_SIGNED    out  1       memory sign-extend select
//  - MEM_DATA_OUT  in   32      memory read data (updated on negedge)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (MEM_* , ACKs, RDATAs, LS_ERR); rr pointer per IF_FIRST.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. REQs sampled only in IDLE.
//  - IDLE, edge N, any REQ: grant; register MEM_ADDR/SIZE/SIGNED/DATA_IN; MEM_WE = LS_WE if LS.
//    IF grant forces MEM_SIZE=10, MEM_SIGNED=0, MEM_WE=0. -> ACCESS.
//  - Memory acts on negedge inside ACCESS. Edge N+1: capture MEM_DATA_OUT into granted RDATA
//    (loads/fetches only; store leaves LS_RDATA unchanged); pulse granted ACK; MEM_WE=0; -> RESP.
//  - Edge N+2: ACK=0; -> IDLE; REQs ignored this edge (requester drops/updates REQ here).
//  - Latency REQ-sampled to ACK-high: 1 cycle; throughput 1 access per 3 cycles.
//  - MEM_WE high only during ACCESS; never two consecutive cycles; never for IF.
//  - Conflict (both REQ in IDLE): grant requester != last granted; pointer updates on each grant.
//  - Single REQ: granted immediately regardless of pointer.
//  - Address wrap (ADDR+1..3 past 16'hFFFF) is the memory's concern; forwarded unmodified.
//  - RST mid-ACCESS: MEM_WE drops asynchronously; write suppressed if RST precedes the negedge;
//    no ACK issued; requester must re-request.
//  - LS_SIZE=11 without macro: forwarded as-is; LS_ACK still pulses; LS_RDATA = captured value.
// CONFIGURATION
//  - MEM_ALIGN_CHECK_EN defined: in IDLE, LS request with size 11, half with ADDR[0]=1, or word
//    with ADDR[1:0]!=0 is not issued (MEM_WE stays 0); -> ACCESS/RESP timing unchanged;
//    LS_ACK with LS_ERR=1, LS_RDATA unchanged. Legal accesses: LS_ERR=0.
//  - Undefined: no checks, LS_ERR tied 0.
// STRUCTURE
//  - Shared include mem_defs.vh: SIZE_BYTE/HALF/WORD/INV codes, FSM state encodings, GNT_IF/GNT_LS.
//  - Sub-module mem_rr_pick: 2-way round-robin picker (req[1:0], last, gnt[1:0]); rest inline.
// TESTING
//  - IF only, IF_ADDR=16'h0010, mem word 32'hDEADBEEF -> IF_ACK 1 cycle after grant, IF_RDATA=DEADBEEF, MEM_WE never 1.
//  - LS store word 32'h11223344 @16'h0020, then load byte signed @16'h0023 -> LS_RDATA=32'h00000011; half signed @0x22 after storing 16'h8001 there -> 32'hFFFF8001.
//  - IF_REQ and LS_REQ held together 6 accesses from reset (IF_FIRST=1) -> grants IF,LS,IF,LS,IF,LS; one ACK per 3 cycles.
//  - Store in flight, RST asserted before negedge of ACCESS -> MEM_WE 0 at negedge, byte unchanged, no LS_ACK, state IDLE.
//  - MEM_ALIGN_CHECK_EN: word store @16'h0021 -> LS_ERR=1 with LS_ACK, memory unchanged; @16'h0020 -> LS_ERR=0.
//  - REQ held across RESP edge -> not re-granted until following IDLE edge; exactly one ACK per request.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: access size codes,
// FSM state encoding, grant identifiers and the alignment rule used when
// the MEM_ALIGN_CHECK_EN build option is enabled.
package mem_port_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_INV  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Requester identifiers; also the bit positions in the req/gnt vectors.
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_LS = 1'b1;

    // An access is misaligned when its size is invalid or its address is not
    // a multiple of its width.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            SIZE_INV:  bad = 1'b1;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin picker. A lone request is granted directly; when both
// requesters ask, the one that was not granted last wins.
module mem_rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Pick one requester, favouring the one not served last on a tie.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            if (last == GNT_LS) begin
                gnt[GNT_IF] = 1'b1;
            end else begin
                gnt[GNT_LS] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port byte-addressed memory between instruction fetch
// (IF) and load/store (LS). One access is in flight at a time; the FSM walks
// IDLE -> ACCESS -> RESP -> IDLE, so one access completes every three cycles.
// Optional build macro: MEM_ALIGN_CHECK_EN rejects invalid-size and
// misaligned LS accesses with LS_ERR instead of issuing them to memory.
//
// Handshake: a requester raises *_REQ with its address/controls and holds
// them stable until its *_ACK. Requests are sampled only in IDLE. *_ACK is a
// one-cycle pulse, with *_RDATA (and LS_ERR) valid in that same cycle. The
// requester drops or replaces its request in the cycle *_ACK is high; the
// following edge ignores requests, so a held request is served once per ACK.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int IF_FIRST = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic              IF_ACK,
    output logic [DATA_W-1:0] IF_RDATA,
    input  logic              LS_REQ,
    input  logic              LS_WE,
    input  logic [ADDR_W-1:0] LS_ADDR,
    input  logic [DATA_W-1:0] LS_WDATA,
    input  logic [1:0]        LS_SIZE,
    input  logic              LS_SIGNED,
    output logic              LS_ACK,
    output logic [DATA_W-1:0] LS_RDATA,
    output logic              LS_ERR,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA_IN,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGNED,
    input  logic [DATA_W-1:0] MEM_DATA_OUT,
    output logic [1:0]        DBG_STATE
);

    state_t     state;
    logic       last_gnt;   // requester granted most recently
    logic       owner_ls;   // current access belongs to LS
    logic       ls_load;    // current LS access is a load
    logic       err_pend;   // current LS access was rejected, not issued
    logic       ls_bad;
    logic [1:0] req;
    logic [1:0] gnt;

    assign req       = {LS_REQ, IF_REQ};
    assign DBG_STATE = state;

`ifdef MEM_ALIGN_CHECK_EN
    assign ls_bad = is_misaligned(LS_SIZE, LS_ADDR[1:0]);
`else
    assign ls_bad = 1'b0;
`endif

    mem_rr_pick u_pick (
        .req  (req),
        .last (last_gnt),
        .gnt  (gnt)
    );

    // Arbitration FSM with registered memory bus and response outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            last_gnt    <= (IF_FIRST != 0) ? GNT_LS : GNT_IF;
            owner_ls    <= 1'b0;
            ls_load     <= 1'b0;
            err_pend    <= 1'b0;
            IF_ACK      <= 1'b0;
            IF_RDATA    <= '0;
            LS_ACK      <= 1'b0;
            LS_RDATA    <= '0;
            LS_ERR      <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_DATA_IN <= '0;
            MEM_SIZE    <= SIZE_BYTE;
            MEM_SIGNED  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt[GNT_LS]) begin
                        MEM_ADDR    <= LS_ADDR;
                        MEM_SIZE    <= LS_SIZE;
                        MEM_SIGNED  <= LS_SIGNED;
                        MEM_DATA_IN <= LS_WDATA;
                        MEM_WE      <= LS_WE & ~ls_bad;
                        ls_load     <= ~LS_WE;
                        err_pend    <= ls_bad;
                        owner_ls    <= 1'b1;
                        last_gnt    <= GNT_LS;
                        state       <= ST_ACCESS;
                    end else if (gnt[GNT_IF]) begin
                        MEM_ADDR    <= IF_ADDR;
                        MEM_SIZE    <= SIZE_WORD;
                        MEM_SIGNED  <= 1'b0;
                        MEM_DATA_IN <= '0;
                        MEM_WE      <= 1'b0;
                        ls_load     <= 1'b0;
                        err_pend    <= 1'b0;
                        owner_ls    <= 1'b0;
                        last_gnt    <= GNT_IF;
                        state       <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Memory acted on the negedge; its read data is stable now.
                    MEM_WE <= 1'b0;
                    if (owner_ls) begin
                        LS_ACK <= 1'b1;
                        LS_ERR <= err_pend;
                        if (ls_load && !err_pend) begin
                            LS_RDATA <= MEM_DATA_OUT;
                        end
                    end else begin
                        IF_ACK   <= 1'b1;
                        IF_RDATA <= MEM_DATA_OUT;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    IF_ACK <= 1'b0;
                    LS_ACK <= 1'b0;
                    LS_ERR <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a negedge byte memory drives MEM_DATA_OUT,
// a directed vector table covers the documented data cases, hand sequences
// cover reset, held-request and tie behaviour, and randomized rounds are
// scored against a transaction-level model of memory and arbitration.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [15:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [1:0]  ls_size = '0;
    logic        ls_signed = 1'b0;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] mem_data_out = '0;
    logic [1:0]  dbg_state;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .IF_FIRST(1)) dut (
        .CLK(clk), .RST(rst),
        .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(if_ack), .IF_RDATA(if_rdata),
        .LS_REQ(ls_req), .LS_WE(ls_we), .LS_ADDR(ls_addr), .LS_WDATA(ls_wdata),
        .LS_SIZE(ls_size), .LS_SIGNED(ls_signed), .LS_ACK(ls_ack),
        .LS_RDATA(ls_rdata), .LS_ERR(ls_err),
        .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_DATA_IN(mem_data_in),
        .MEM_SIZE(mem_size), .MEM_SIGNED(mem_signed), .MEM_DATA_OUT(mem_data_out),
        .DBG_STATE(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory environment ----------------
    logic [7:0]  mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    bit          mem_ready = 1'b0;
    logic [15:0] ea1, ea2, ea3;
    logic [7:0]  eb0, eb1, eb2, eb3;

    function automatic logic [7:0] fill_byte(input int a);
        return 8'((a * 29) ^ (a >> 5) ^ 60);
    endfunction

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 65536; a++) mem[a] = fill_byte(a);
            mem[16'h10] = 8'hEF;
            mem[16'h11] = 8'hBE;
            mem[16'h12] = 8'hAD;
            mem[16'h13] = 8'hDE;
            mem[16'h40] = 8'h5A;
            mem_ready = 1'b1;
        end
        ea1 = mem_addr + 16'd1;
        ea2 = mem_addr + 16'd2;
        ea3 = mem_addr + 16'd3;
        eb0 = mem[mem_addr];
        eb1 = mem[ea1];
        eb2 = mem[ea2];
        eb3 = mem[ea3];
        case (mem_size)
            2'b00:   mem_data_out <= {{24{mem_signed & eb0[7]}}, eb0};
            2'b01:   mem_data_out <= {{16{mem_signed & eb1[7]}}, eb1, eb0};
            default: mem_data_out <= {eb3, eb2, eb1, eb0};
        endcase
        if (mem_we) begin
            case (mem_size)
                2'b00: mem[mem_addr] = mem_data_in[7:0];
                2'b01: begin
                    mem[mem_addr] = mem_data_in[7:0];
                    mem[ea1]      = mem_data_in[15:8];
                end
                2'b10: begin
                    mem[mem_addr] = mem_data_in[7:0];
                    mem[ea1]      = mem_data_in[15:8];
                    mem[ea2]      = mem_data_in[23:16];
                    mem[ea3]      = mem_data_in[31:24];
                end
                default: ;
            endcase
        end
    end

    // MEM_WE must appear only in ACCESS and never on two consecutive negedges.
    int we_cnt = 0;
    int viol = 0;
    bit prev_we = 1'b0;
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            if (prev_we || dbg_state != 2'(ST_ACCESS)) viol++;
        end
        prev_we = mem_we;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int we_exp = 0;
    bit src_q[$];
    logic [31:0] exp_q[$];
    bit err_q[$];
    int ack_t[$];
    bit last_model = 1'b1;
    logic [31:0] ls_prev = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic got_ack(input bit is_ls, input logic [31:0] d, input bit e, input int c);
        ack_t.push_back(c);
        if (src_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack from %s expected none at %0t",
                     is_ls ? "LS" : "IF", $time);
        end else begin
            check("ack_source", 32'(is_ls), 32'(src_q.pop_front()));
            check("rdata", d, exp_q.pop_front());
            check("ls_err", 32'(e), 32'(err_q.pop_front()));
        end
    endtask

    task automatic sample_acks(input int c, input bit drop);
        if (if_ack) begin
            got_ack(1'b0, if_rdata, 1'b0, c);
            if (drop) if_req = 1'b0;
        end
        if (ls_ack) begin
            got_ack(1'b1, ls_rdata, ls_err, c);
            if (drop) ls_req = 1'b0;
        end
    endtask

    task automatic finish_round(input int n_exp, input int t0, input int t1);
        check("ack_count", ack_t.size(), n_exp);
        if (ack_t.size() > 0) check("ack_cycle_first", ack_t[0], t0);
        if (ack_t.size() > 1) check("ack_cycle_second", ack_t[1], t1);
        check("pending_acks", src_q.size(), 0);
        check("back_to_idle", dbg_state, ST_IDLE);
        src_q.delete();
        exp_q.delete();
        err_q.delete();
        ack_t.delete();
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_read(input logic [15:0] a, input logic [1:0] sz, input bit sg);
        int n;
        longint v;
        n = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[16'(a + 16'(i))]) << (8 * i);
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_write(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n;
        n = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[16'(a + 16'(i))] = 8'(wd >> (8 * i));
    endtask

    task automatic model_if(input logic [15:0] a);
        src_q.push_back(1'b0);
        exp_q.push_back(ref_read(a, SIZE_WORD, 1'b0));
        err_q.push_back(1'b0);
    endtask

    task automatic model_ls(input bit we, input logic [15:0] a, input logic [31:0] wd,
                            input logic [1:0] sz, input bit sg);
        bit bad;
        int width;
        width = 1 << sz;
        bad = ALIGN_CHK && (sz == SIZE_INV || (int'(a) % width) != 0);
        if (!bad && we) begin
            we_exp++;
            if (sz != SIZE_INV) ref_write(a, sz, wd);
        end
        if (!bad && !we) ls_prev = ref_read(a, sz, sg);
        src_q.push_back(1'b1);
        exp_q.push_back(ls_prev);
        err_q.push_back(bad);
    endtask

    task automatic run_round(input bit use_if, input logic [15:0] ia,
                             input bit use_ls, input bit we, input logic [15:0] la,
                             input logic [31:0] wd, input logic [1:0] sz, input bit sg);
        bit ls_first;
        int steps;
        ls_first = use_ls && (!use_if || last_model == 1'b0);
        if (ls_first) begin
            model_ls(we, la, wd, sz, sg);
            if (use_if) model_if(ia);
        end else begin
            if (use_if) model_if(ia);
            if (use_ls) model_ls(we, la, wd, sz, sg);
        end
        if (use_if && use_ls) last_model = ls_first ? 1'b0 : 1'b1;
        else last_model = use_ls;
        if_req = use_if; if_addr = ia;
        ls_req = use_ls; ls_we = we; ls_addr = la; ls_wdata = wd;
        ls_size = sz; ls_signed = sg;
        steps = (use_if && use_ls) ? 6 : 3;
        for (int c = 1; c <= steps; c++) begin
            step();
            sample_acks(c, 1'b1);
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        finish_round((use_if && use_ls) ? 2 : 1, 2, 5);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 16'hFFFC + 16'($urandom_range(0, 3));
        return 16'h0100 + 16'($urandom_range(0, 63));
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          is_ls;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic apply_vec(input vec_t v);
        src_q.push_back(v.is_ls);
        exp_q.push_back(v.exp_rdata);
        err_q.push_back(v.exp_err);
        if (v.is_ls && v.we && !v.exp_err) we_exp++;
        if_req = !v.is_ls; if_addr = v.addr;
        ls_req = v.is_ls; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
        ls_size = v.size; ls_signed = v.sgn;
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 1) begin
                check("grant_addr", mem_addr, v.addr);
                check("grant_we", 32'(mem_we), 32'(v.is_ls && v.we && !v.exp_err));
                if (!v.is_ls) begin
                    check("if_size", mem_size, SIZE_WORD);
                    check("if_signed", 32'(mem_signed), 0);
                end
            end
            sample_acks(c, 1'b1);
        end
        finish_round(1, 2, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n_ack;
        for (int a = 0; a < 65536; a++) ref_mem[a] = fill_byte(a);

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 32'h0, SIZE_WORD, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'h0020, 32'h11223344, SIZE_WORD, 1'b0, 32'h00000000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h0023, 32'h0, SIZE_BYTE, 1'b1, 32'h00000011, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'h0022, 32'h00008001, SIZE_HALF, 1'b0, 32'h00000011, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0022, 32'h0, SIZE_HALF, 1'b1, 32'hFFFF8001, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'h0023, 32'h0, SIZE_BYTE, 1'b1, 32'hFFFFFF80, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'h0022, 32'h0, SIZE_BYTE, 1'b0, 32'h00000001, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 16'h0020, 32'h0, SIZE_WORD, 1'b0, 32'h80013344, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 16'h0021, 32'hAABBCCDD, SIZE_WORD, 1'b0, 32'h00000001, ALIGN_CHK};
        vecs[9] = '{1'b1, 1'b0, 16'h0020, 32'h0, SIZE_WORD, 1'b0,
                    ALIGN_CHK ? 32'h80013344 : 32'hBBCCDD44, 1'b0};

        // Reset and reset values.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_acks", {30'd0, if_ack, ls_ack}, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_ls_rdata", ls_rdata, 0);
        check("rst_ls_err", 32'(ls_err), 0);
        check("rst_mem_ctl", {28'd0, mem_we, mem_size, mem_signed}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data_in", mem_data_in, 0);

        // Directed vectors.
        for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

        // Request held across the RESP edge is not re-granted there.
        src_q.push_back(1'b0);
        exp_q.push_back(32'hDEADBEEF);
        err_q.push_back(1'b0);
        if_req = 1'b1;
        if_addr = 16'h0010;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 3) begin
                check("held_req_idle", dbg_state, ST_IDLE);
                if_req = 1'b0;
            end
            sample_acks(c, 1'b0);
        end
        finish_round(1, 2, 0);

        // Reset during a store's ACCESS cycle, before the memory negedge.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0040; ls_wdata = 32'h000000A5;
        ls_size = SIZE_BYTE; ls_signed = 1'b0;
        step();
        check("store_access_state", dbg_state, ST_ACCESS);
        check("store_we_high", 32'(mem_we), 1);
        rst = 1'b1;
        #1;
        check("rst_we_async", 32'(mem_we), 0);
        check("rst_state_async", dbg_state, ST_IDLE);
        @(negedge clk);
        #1;
        check("rst_write_suppressed", mem[16'h40], 32'h5A);
        ls_req = 1'b0;
        n_ack = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 1) rst = 1'b0;
            if (ls_ack || if_ack) n_ack++;
        end
        check("rst_no_ack", n_ack, 0);
        check("rst_end_state", dbg_state, ST_IDLE);
        check("rst_byte_final", mem[16'h40], 32'h5A);

        // Both requesters held from reset: IF,LS,IF,LS,IF,LS, one ACK per 3 cycles.
        for (int k = 0; k < 6; k++) begin
            src_q.push_back(k[0]);
            exp_q.push_back(32'hDEADBEEF);
            err_q.push_back(1'b0);
        end
        if_req = 1'b1; if_addr = 16'h0010;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0010; ls_size = SIZE_WORD; ls_signed = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            step();
            sample_acks(c, 1'b0);
            if (ack_t.size() == 6) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
        end
        check("tie_ack_count", ack_t.size(), 6);
        for (int k = 0; k + 1 < ack_t.size(); k++) check("tie_ack_spacing", ack_t[k + 1] - ack_t[k], 3);
        finish_round(6, 2, 5);
        last_model = 1'b1;
        ls_prev = 32'hDEADBEEF;

        // Randomized rounds against the reference model.
        for (int r = 0; r < 40; r++) begin
            int mode;
            int szr;
            mode = $urandom_range(0, 2);
            szr = $urandom_range(0, 9);
            run_round(mode != 1, rand_addr(), mode != 0, 1'($urandom_range(0, 1)),
                      rand_addr(), $urandom, (szr == 9) ? SIZE_INV : 2'(szr % 3),
                      1'($urandom_range(0, 1)));
        end

        check("we_rule_violations", viol, 0);
        check("mem_we_pulses", we_cnt, we_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
